// File: rtl/sort_e2_lane_pkg.sv
// rtl/sort_e2_lane_pkg.sv - shared widths, slot count and guard constants for the E2 top-5 lane
package sort_e2_lane_pkg;

  // Default score and index widths; an entry is {index, data} with data in the LSBs
  localparam int DATA_W  = 8;
  localparam int INDEX_W = 16;

  // Number of kept entries and minimum spacing between result pulses
  localparam int K       = 5;
  localparam int GUARD   = 8;
  localparam int GUARD_W = 3;

  // Empty-slot score: most-negative value, index 0
  localparam logic [DATA_W-1:0] MIN_DATA = 8'h80;

  typedef logic [GUARD_W-1:0] guard_t;

endpackage

// File: rtl/topk5_insert.sv
// rtl/topk5_insert.sv - combinational insertion of one entry into a descending 5-entry list
module topk5_insert
  import sort_e2_lane_pkg::*;
#(
  parameter int Data_Width  = DATA_W,
  parameter int Index_Width = INDEX_W
) (
  input  logic [Data_Width+Index_Width-1:0] cur [K],
  input  logic [Data_Width+Index_Width-1:0] ent,
  output logic [Data_Width+Index_Width-1:0] nxt [K]
);

  // gt is a thermometer (0..0 1..1) because cur is sorted descending;
  // strictly-greater keeps earlier equal scores above the new one
  logic [K-1:0] gt;

  // Compare the new score against every slot
  always_comb begin
    gt = '0;
    for (int i = 0; i < K; i++) begin
      gt[i] = $signed(ent[Data_Width-1:0]) > $signed(cur[i][Data_Width-1:0]);
    end
  end

  // First slot that loses takes the new entry, slots below shift down, last drops out
  always_comb begin
    for (int i = 0; i < K; i++) begin
      nxt[i] = cur[i];
    end
    nxt[0] = gt[0] ? ent : cur[0];
    for (int i = 1; i < K; i++) begin
      if (gt[i]) begin
        nxt[i] = gt[i-1] ? cur[i-1] : ent;
      end
    end
  end

endmodule

// File: rtl/sort_e2_lane.sv
// rtl/sort_e2_lane.sv - streaming per-group top-5 selector feeding the E3 merge stage
module sort_e2_lane
  import sort_e2_lane_pkg::*;
#(
  parameter int                    Data_Width  = DATA_W,
  parameter int                    Index_Width = INDEX_W,
  parameter logic [Data_Width-1:0] MIN         = MIN_DATA
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              sorter_clr,
  input  logic                              data_in_valid,
  input  logic [Data_Width-1:0]             data_in,
  input  logic                              data_in_last,
  input  logic                              job_last_in,
  output logic                              data_in_ready,
  output logic [Index_Width+Data_Width-1:0] E2_sorter_out0,
  output logic [Index_Width+Data_Width-1:0] E2_sorter_out1,
  output logic [Index_Width+Data_Width-1:0] E2_sorter_out2,
  output logic [Index_Width+Data_Width-1:0] E2_sorter_out3,
  output logic [Index_Width+Data_Width-1:0] E2_sorter_out4,
  output logic                              E2_sort_en,
  output logic                              E2_last_sort
);

  localparam int                EW       = Index_Width + Data_Width;
  localparam logic [EW-1:0]     MIN_WORD = {{Index_Width{1'b0}}, MIN};

  logic [Index_Width-1:0] idx;
  logic [EW-1:0]          w   [K];
  logic [EW-1:0]          ins [K];
  logic [EW-1:0]          res [K];
  guard_t                 g;
  logic                   accept;
  logic [EW-1:0]          new_entry;

  assign data_in_ready = (g == '0);
  assign accept        = data_in_valid && data_in_ready;
  assign new_entry     = {idx, data_in};

  topk5_insert #(
    .Data_Width  (Data_Width),
    .Index_Width (Index_Width)
  ) u_insert (
    .cur (w),
    .ent (new_entry),
    .nxt (ins)
  );

  // Index, work array, held result, guard counter and result pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx          <= '0;
      g            <= '0;
      E2_sort_en   <= 1'b0;
      E2_last_sort <= 1'b0;
      for (int i = 0; i < K; i++) begin
        w[i]   <= MIN_WORD;
        res[i] <= '0;
      end
    end else if (sorter_clr) begin
      idx          <= '0;
      g            <= '0;
      E2_sort_en   <= 1'b0;
      E2_last_sort <= 1'b0;
      for (int i = 0; i < K; i++) begin
        w[i]   <= MIN_WORD;
        res[i] <= '0;
      end
    end else begin
      E2_sort_en   <= 1'b0;
      E2_last_sort <= 1'b0;
      if (g != '0) begin
        g <= g - guard_t'(1);
      end
      if (accept) begin
        idx <= idx + 1'b1;
        if (data_in_last) begin
          // Publish the array including this element and start a fresh group
          for (int i = 0; i < K; i++) begin
            res[i] <= ins[i];
            w[i]   <= MIN_WORD;
          end
          g            <= guard_t'(GUARD - 1);
          E2_sort_en   <= 1'b1;
          E2_last_sort <= job_last_in;
        end else begin
          for (int i = 0; i < K; i++) begin
            w[i] <= ins[i];
          end
        end
      end
    end
  end

  assign E2_sorter_out0 = res[0];
  assign E2_sorter_out1 = res[1];
  assign E2_sorter_out2 = res[2];
  assign E2_sorter_out3 = res[3];
  assign E2_sorter_out4 = res[4];

endmodule

// File: tb/tb_sort_e2_lane.sv
// tb/tb_sort_e2_lane.sv - randomized and directed self-checking bench for sort_e2_lane
module tb_sort_e2_lane;

  localparam logic [23:0] MINW = 24'h000080;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr   = 1'b0;
  logic        vld   = 1'b0;
  logic        last  = 1'b0;
  logic        jl    = 1'b0;
  logic [7:0]  din   = 8'h00;
  logic        rdy;
  logic        sen;
  logic        lsort;
  logic [23:0] o [5];

  always #5 clk = ~clk;

  sort_e2_lane dut (
    .sys_clk        (clk),
    .sys_rst_n      (rst_n),
    .sorter_clr     (clr),
    .data_in_valid  (vld),
    .data_in        (din),
    .data_in_last   (last),
    .job_last_in    (jl),
    .data_in_ready  (rdy),
    .E2_sorter_out0 (o[0]),
    .E2_sorter_out1 (o[1]),
    .E2_sorter_out2 (o[2]),
    .E2_sorter_out3 (o[3]),
    .E2_sorter_out4 (o[4]),
    .E2_sort_en     (sen),
    .E2_last_sort   (lsort)
  );

  int          n_total  = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          last_end = -1000;
  logic [15:0] m_idx    = 16'h0000;
  logic [23:0] grp [$];
  logic [23:0] m_out [5];
  bit          m_pend   = 1'b0;
  bit          m_last   = 1'b0;
  bit          acc_flag = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Top 5 of the group by score, earlier arrival wins ties, -128 counts as empty
  function automatic void model_result();
    int pick [5];
    for (int k = 0; k < 5; k++) begin
      int best = -1;
      for (int j = 0; j < grp.size(); j++) begin
        bit used = 1'b0;
        logic [23:0] e = grp[j];
        logic [23:0] b;
        if (e[7:0] == 8'h80) continue;
        for (int p = 0; p < k; p++) if (pick[p] == j) used = 1'b1;
        if (used) continue;
        if (best < 0) best = j;
        else begin
          b = grp[best];
          if ($signed(e[7:0]) > $signed(b[7:0])) best = j;
        end
      end
      pick[k]  = best;
      m_out[k] = (best < 0) ? MINW : grp[best];
    end
  endfunction

  task automatic model_clear();
    grp.delete();
    m_idx    = 16'h0000;
    m_pend   = 1'b0;
    m_last   = 1'b0;
    last_end = -1000;
    for (int k = 0; k < 5; k++) m_out[k] = 24'h0;
  endtask

  // One clock cycle; entered and left just after a falling edge
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit j, input bit c);
    bit mrdy;
    vld  = v;
    din  = d;
    last = l;
    jl   = j;
    clr  = c;
    mrdy = (cyc - last_end) >= 8;
    check("ready", 64'(rdy), 64'(mrdy));
    acc_flag = 1'b0;
    m_pend   = 1'b0;
    if (c) begin
      model_clear();
    end else if (v && mrdy) begin
      acc_flag = 1'b1;
      grp.push_back({m_idx, d});
      m_idx++;
      if (l) begin
        model_result();
        grp.delete();
        m_pend   = 1'b1;
        m_last   = j;
        last_end = cyc;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("sort_en", 64'(sen), 64'(m_pend));
    if (m_pend) check("last_sort", 64'(lsort), 64'(m_last));
    for (int k = 0; k < 5; k++) check($sformatf("out%0d", k), 64'(o[k]), 64'(m_out[k]));
  endtask

  task automatic send(input logic [7:0] d, input bit l, input bit j);
    int n = 0;
    do begin
      step(1'b1, d, l, j, 1'b0);
      n++;
    end while (!acc_flag && n < 20);
    check("send_accept", 64'(acc_flag), 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld   = 1'b0;
    clr   = 1'b0;
    last  = 1'b0;
    #2;
    model_clear();
    check("rst_sort_en", 64'(sen), 64'd0);
    check("rst_ready", 64'(rdy), 64'd1);
    for (int k = 0; k < 5; k++) check($sformatf("rst_out%0d", k), 64'(o[k]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] exp_basic [5];
    logic [23:0] exp_short [5];
    int          prev_acc;
    exp_basic = '{24'h00017F, 24'h00037F, 24'h000420, 24'h000010, 24'h000205};
    exp_short = '{24'h000601, 24'h0007FF, MINW, MINW, MINW};

    @(negedge clk);
    do_reset();

    // Basic group
    send(8'h10, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'h05, 1'b0, 1'b0);
    send(8'h7F, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    send(8'h81, 1'b1, 1'b0);
    check("basic_pulse", 64'(sen), 64'd1);
    check("basic_last", 64'(lsort), 64'd0);
    for (int k = 0; k < 5; k++) check($sformatf("basic_out%0d", k), 64'(o[k]), 64'(exp_basic[k]));

    // Short group ending the job
    send(8'h01, 1'b0, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    check("short_last", 64'(lsort), 64'd1);
    for (int k = 0; k < 5; k++) check($sformatf("short_out%0d", k), 64'(o[k]), 64'(exp_short[k]));

    // Back-to-back single-element groups with valid held high
    prev_acc = -1;
    for (int n = 0; n < 6; n++) begin
      send(8'($urandom), 1'b1, 1'b0);
      if (prev_acc >= 0) check("b2b_gap", 64'(cyc - 1 - prev_acc), 64'd8);
      prev_acc = cyc - 1;
    end

    // Clear coinciding with an accept mid-group
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    check("clr_no_pulse", 64'(sen), 64'd0);
    send(8'h40, 1'b1, 1'b0);
    check("clr_out0", 64'(o[0]), 64'h000040);
    for (int k = 1; k < 5; k++) check($sformatf("clr_out%0d", k), 64'(o[k]), 64'(MINW));

    // Randomized traffic with occasional clear and mid-group reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 5) == 0,
             1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
      end
    end

    // Index wrap inside one long group
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 65536; n++) begin
      logic [7:0] d;
      d = (n >= 65535) ? 8'h7F : 8'($urandom_range(0, 254) + 128);
      send(d, n == 65536, 1'b0);
    end
    check("wrap_out0", 64'(o[0]), 64'hFFFF7F);
    check("wrap_out1", 64'(o[1]), 64'h00007F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sort_e2_lane.md
# sort_e2_lane

Streaming top-5 selector that sits directly upstream of the E3 merge stage. Each instance consumes one lane of signed scores, one element per cycle. It tags each element with a running index and keeps the 5 largest elements of the current group. At group end it presents them, sorted, on a held output bus with a one-cycle `E2_sort_en` pulse. Two instances (H and L lanes) feed the E3 merger's `E2H_*`/`E2L_*` inputs.

## Interface
- `Data_Width`, 8, signed two's-complement score width
- `Index_Width`, 16, element index width
- `MIN`, 8'h80, empty-slot word (zero-extended to full entry width: index 0, most-negative data)
- `sys_clk` in 1 — rising-edge clock
- `sys_rst_n` in 1 — reset; single clock domain, asynchronous, active-low
- `sorter_clr` in 1 — synchronous clear, same effect as reset
- `data_in_valid` in 1 — element present
- `data_in` in `Data_Width` — signed score
- `data_in_last` in 1 — element is last of its group; qualified by the accept condition
- `job_last_in` in 1 — group is the last of the job; sampled with `data_in_last`
- `data_in_ready` out 1 — the block can accept an element this cycle
- `E2_sorter_out0..4` out `Index_Width+Data_Width` each — `{index, data}`; out0 holds the largest entry
- `E2_sort_en` out 1 — one-cycle result-valid pulse
- `E2_last_sort` out 1 — coincident with `E2_sort_en`; marks the job's final group

## Operation
- An element is accepted when `data_in_valid && data_in_ready`.
- Index counter `idx` (`Index_Width`):
  - The accepted element takes the current `idx`; `idx` then increments.
  - Wraps from 0xFFFF to 0.
  - Not reset per group; cleared only by reset or `sorter_clr`.
- Work array `w0..w4` (full entry width):
  - Reset value is `MIN` in every slot.
  - Kept sorted descending by the signed data field.
  - On accept, the new entry is inserted at the first slot whose data is strictly smaller. Lower slots shift down one place and `w4` drops out.
  - Ties keep the earlier (lower-index) element higher. A score of 0x80 never displaces an empty slot.
- Group end (accept with `data_in_last=1`):
  - `E2_sorter_out0..4` load the post-insertion array, so the last element is included.
  - `E2_sort_en` pulses high and `E2_last_sort` is set to `job_last_in`.
  - `w0..w4` reset to `MIN` in the same cycle.
- Output hold: `E2_sorter_out*` change only at group end, reset, or clear. E3 reads them for 5 iterations after the pulse.
- Guard counter `g` (3 bit):
  - Loads 7 at group end and decrements to 0.
  - `data_in_ready = (g == 0)`.
  - This guarantees at least 8 cycles between `E2_sort_en` pulses, which E3 needs to finish its 5 iterations and update its feedback outputs.
- `sorter_clr` has priority over an accept in the same cycle:
  - `idx` goes to 0 and `w*` to `MIN`.
  - Outputs go to 0, `g` to 0, pulses to 0.
  - The accepted element is discarded.

## Timing
- Reset values:
  - `E2_sorter_out0..4` = 0.
  - `E2_sort_en` = 0.
  - `E2_last_sort` = 0.
  - `data_in_ready` = 1.
- Element accepted at edge t is visible in `w*` after edge t.
- Latency: a group-end accept at edge t gives `E2_sort_en` high and new outputs during cycle t+1, one cycle after acceptance.
- `data_in_ready` is low from cycle t+1 through t+7 and high at t+8.
- Back-to-back: the earliest next pulse is at t+9, so the pulse spacing is at least 8 cycles.
- A single-element group is legal. Untouched slots then output `MIN` (0x000080).
- `data_in_valid` while ready is low: the element is held off, not dropped. The upstream must keep it stable.
- Reset asserted mid-group: all state is lost and no pulse is issued.

## Structure
- Shared header `sort_defs.vh` holds:
  - `Data_Width`, `Index_Width`, `MIN`
  - `K` = 5
  - `GUARD` = 8
  - The entry field positions (data in the LSBs, index in the MSBs), shared with the E3 merger and `max16`.
- Sub-module `topk5_insert` is purely combinational:
  - Inputs: 5 sorted entries plus 1 new entry.
  - Output: 5 sorted entries.
  - Uses signed compare with strictly-greater insertion.

## Test plan
- Reset:
  - Stimulus: assert `sys_rst_n` low with no traffic.
  - Response: outputs all 0, `E2_sort_en`=0, `data_in_ready`=1.
- Basic group:
  - Stimulus: data 0x10, 0x7F, 0x05, 0x7F, 0x20, 0x81 (indices 0–5), last on 0x81.
  - Response: out0..4 = 0x00017F, 0x00037F, 0x000420, 0x000010, 0x000205. One pulse, `E2_last_sort`=0.
- Short group:
  - Stimulus: second group 0x01, 0xFF with last; `job_last_in`=1.
  - Response: out0..4 = 0x000601, 0x0007FF, 0x000080, 0x000080, 0x000080. `E2_last_sort`=1.
- Back-to-back:
  - Stimulus: valid held high continuously, with groups of length 1.
  - Response: ready low for 7 cycles after each pulse; pulses exactly 8 cycles apart; no element lost.
- Clear mid-group:
  - Stimulus: 3 elements, then `sorter_clr` coinciding with an accept, then a 1-element group of 0x40.
  - Response: no pulse from the clear. The next result is out0 = 0x000040, rest 0x000080.
- Index wrap:
  - Stimulus: 65537 elements in one group, with score 0x7F at index 0xFFFF and at the following element.
  - Response: out0 = 0xFFFF7F, out1 = 0x00007F.
